// File: rtl/systolic_pkg.sv
// Shared constants, FSM state type and segment-length helper for the 4x4 systolic
// matrix-multiply accelerator.
package systolic_pkg;

    localparam int N          = 4;
    localparam int DATA_W     = 16;
    localparam int ACC_W      = 32;
    localparam int MEM_COLS   = 256;
    localparam int INST_DEPTH = 8;
    localparam int OUT_DEPTH  = 128;
    localparam int DRAIN_CYC  = 8;

    localparam int COL_W = $clog2(MEM_COLS);
    localparam int K_W   = 5;
    localparam int CNT_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_STORE,
        ST_DONE
    } state_t;

    // Every segment after the first carries one extra lead-in column.
    function automatic logic [CNT_W-1:0] seg_len(input logic [K_W-1:0] k, input logic later);
        return CNT_W'(k) + CNT_W'(6) + CNT_W'(later);
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// Output-stationary processing element: multiply-accumulate plus right/down operand forwarding.
// Define SYSTOLIC_SAT_EN for saturating accumulation instead of two's-complement wrap.
module systolic_pe
    import systolic_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic signed [DATA_W-1:0] a_in,
    input  logic signed [DATA_W-1:0] b_in,
    output logic signed [DATA_W-1:0] a_out,
    output logic signed [DATA_W-1:0] b_out,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [DATA_W-1:0] a_d, a_q;
    logic signed [DATA_W-1:0] b_d, b_q;
    logic signed [ACC_W-1:0]  acc_d, acc_q;
    logic signed [ACC_W-1:0]  prod;
`ifdef SYSTOLIC_SAT_EN
    logic        [ACC_W:0]    sum;
`endif

    always_comb begin
        prod = ACC_W'(a_in) * ACC_W'(b_in);
        a_d  = a_in;
        b_d  = b_in;
`ifdef SYSTOLIC_SAT_EN
        // One guard bit exposes overflow; clamp toward the sign of the true sum.
        sum = {acc_q[ACC_W-1], acc_q} + {prod[ACC_W-1], prod};
        if (sum[ACC_W] != sum[ACC_W-1])
            acc_d = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            acc_d = sum[ACC_W-1:0];
`else
        acc_d = acc_q + prod;
`endif
        if (clear) begin
            a_d   = '0;
            b_d   = '0;
            acc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign acc   = acc_q;

endmodule

// File: rtl/systolic_top.sv
// 4x4 systolic matrix-multiply accelerator: host-loaded A/B/instruction memories, sequencing
// FSM, PE grid and result memory. Define SYSTOLIC_SAT_EN for saturating accumulators.
module systolic_top
    import systolic_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  addrA,
    input  logic [15:0] dataA,
    input  logic        enA,
    input  logic [9:0]  addrB,
    input  logic [15:0] dataB,
    input  logic        enB,
    input  logic [2:0]  addrI,
    input  logic [4:0]  dataI,
    input  logic        enI,
    input  logic [6:0]  addrO,
    output logic [31:0] dataO,
    input  logic        ap_start,
    output logic        ap_done,
    output logic [4:0]  currInstruction
);

    logic signed [DATA_W-1:0] mem_a [N][MEM_COLS];
    logic signed [DATA_W-1:0] mem_b [N][MEM_COLS];
    logic        [K_W-1:0]    mem_i [INST_DEPTH];
    logic signed [ACC_W-1:0]  mem_o [OUT_DEPTH];

    state_t           state_d, state_q;
    logic [3:0]       idx_d, idx_q;
    logic [COL_W-1:0] col_d, col_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [K_W-1:0]   k_d, k_q;
    logic [K_W-1:0]   instr;
    logic             clear_pe, streaming, storing, busy;

    logic signed [DATA_W-1:0] edge_a_d [N];
    logic signed [DATA_W-1:0] edge_a_q [N];
    logic signed [DATA_W-1:0] edge_b_d [N];
    logic signed [DATA_W-1:0] edge_b_q [N];
    logic signed [DATA_W-1:0] a_h [N][N+1];
    logic signed [DATA_W-1:0] b_v [N+1][N];
    logic signed [ACC_W-1:0]  acc [N][N];

    assign busy  = !(state_q == ST_IDLE || state_q == ST_DONE);
    assign instr = mem_i[idx_q[2:0]];

    // Memories carry no reset; host writes are locked out while a program runs.
    always_ff @(posedge clk) begin
        if (enA && !busy) mem_a[addrA[9:8]][addrA[7:0]] <= dataA;
        if (enB && !busy) mem_b[addrB[9:8]][addrB[7:0]] <= dataB;
        if (enI && !busy) mem_i[addrI] <= dataI;
        if (storing) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    mem_o[{idx_q[2:0], 2'(r), 2'(c)}] <= acc[r][c];
        end
    end

    assign dataO = mem_o[addrO];

    always_comb begin
        for (int r = 0; r < N; r++) begin
            edge_a_d[r] = streaming ? mem_a[r][col_q] : '0;
            edge_b_d[r] = streaming ? mem_b[r][col_q] : '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        col_d     = col_q;
        cnt_d     = cnt_q;
        k_d       = k_q;
        clear_pe  = 1'b0;
        streaming = 1'b0;
        storing   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (ap_start) begin
                    state_d = ST_FETCH;
                    idx_d   = '0;
                    col_d   = '0;
                    k_d     = '0;
                end
            end
            ST_FETCH: begin
                if (idx_q == 4'(INST_DEPTH) || instr == '0) begin
                    state_d = ST_DONE;
                end else begin
                    k_d     = instr;
                    cnt_d   = '0;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                clear_pe = 1'b1;
                state_d  = ST_STREAM;
            end
            ST_STREAM: begin
                streaming = 1'b1;
                col_d     = col_q + COL_W'(1);
                if (cnt_q == seg_len(k_q, idx_q != '0) - CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CNT_W'(DRAIN_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_STORE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STORE: begin
                storing = 1'b1;
                idx_d   = idx_q + 4'd1;
                state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
            for (int r = 0; r < N; r++) begin
                edge_a_q[r] <= '0;
                edge_b_q[r] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            for (int r = 0; r < N; r++) begin
                edge_a_q[r] <= edge_a_d[r];
                edge_b_q[r] <= edge_b_d[r];
            end
        end
    end

    assign ap_done         = (state_q == ST_DONE);
    assign currInstruction = busy ? k_q : '0;

    // A enters from the left of each row, B from the top of each column; data is pre-skewed.
    generate
        for (genvar r = 0; r < N; r++) begin : g_row
            assign a_h[r][0] = edge_a_q[r];
            assign b_v[0][r] = edge_b_q[r];
            for (genvar c = 0; c < N; c++) begin : g_col
                systolic_pe u_pe (
                    .clk   (clk),
                    .rst   (rst),
                    .clear (clear_pe),
                    .a_in  (a_h[r][c]),
                    .b_in  (b_v[r][c]),
                    .a_out (a_h[r][c+1]),
                    .b_out (b_v[r+1][c]),
                    .acc   (acc[r][c])
                );
            end
        end
    endgenerate

endmodule

// File: tb/tb_systolic_top.sv
// Self-checking bench for systolic_top: matrix-level reference model, randomized programs,
// hand-computed literal pins. Honours SYSTOLIC_SAT_EN when the design is built with it.
`timescale 1ns/1ps
module tb_systolic_top;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  addrA, addrB;
    logic [15:0] dataA, dataB;
    logic        enA, enB;
    logic [2:0]  addrI;
    logic [4:0]  dataI;
    logic        enI;
    logic [6:0]  addrO;
    logic [31:0] dataO;
    logic        ap_start;
    logic        ap_done;
    logic [4:0]  currInstruction;

    systolic_top dut (
        .clk             (clk),
        .rst             (rst),
        .addrA           (addrA),
        .dataA           (dataA),
        .enA             (enA),
        .addrB           (addrB),
        .dataB           (dataB),
        .enB             (enB),
        .addrI           (addrI),
        .dataI           (dataI),
        .enI             (enI),
        .addrO           (addrO),
        .dataO           (dataO),
        .ap_start        (ap_start),
        .ap_done         (ap_done),
        .currInstruction (currInstruction)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Program under test: K per instruction and the plain (unskewed) matrices.
    int                 n_prog;
    int                 kk [8];
    logic signed [15:0] am [8][4][32];
    logic signed [15:0] bm [8][32][4];

    logic [31:0] ref_o [128];
    bit          ref_v [128];
    bit          cmp_en = 1'b0;
    bit          mon_on = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)",
                     name, $signed(act), act, $signed(exp), exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en && ref_v[addrO]) checkOutput("dataO_monitor", dataO, ref_o[addrO]);
        if (mon_on && ap_done) checkOutput("curr_while_done", 32'(currInstruction), 32'd0);
    end

    function automatic logic [31:0] expectedC(input int i, input int r, input int c);
        longint s = 0;
        for (int k = 0; k < kk[i]; k++) begin
            s += longint'(am[i][r][k]) * longint'(bm[i][k][c]);
`ifdef SYSTOLIC_SAT_EN
            if (s > 64'sd2147483647) s = 64'sd2147483647;
            if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
        end
        return s[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeAB(input int a, input logic [15:0] va, input logic [15:0] vb);
        addrA = 10'(a); dataA = va; enA = 1'b1;
        addrB = 10'(a); dataB = vb; enB = 1'b1;
        tick();
        enA = 1'b0; enB = 1'b0;
    endtask

    task automatic writeI(input int a, input int v);
        addrI = 3'(a); dataI = 5'(v); enI = 1'b1;
        tick();
        enI = 1'b0;
    endtask

    // Lay the matrices out as pre-skewed column streams, zero padding included.
    task automatic loadProgram();
        int base = 0;
        for (int i = 0; i < n_prog; i++) begin
            int off = (i > 0) ? 1 : 0;
            int len = kk[i] + 6 + off;
            for (int j = 0; j < len; j++) begin
                for (int r = 0; r < 4; r++) begin
                    int k = j - off - r;
                    logic [15:0] va = '0;
                    logic [15:0] vb = '0;
                    if (k >= 0 && k < kk[i]) begin
                        va = am[i][r][k];
                        vb = bm[i][k][r];
                    end
                    writeAB(256 * r + ((base + j) % 256), va, vb);
                end
            end
            base += len;
        end
        for (int i = 0; i < n_prog; i++) writeI(i, kk[i]);
        if (n_prog < 8) writeI(n_prog, 0);
    endtask

    task automatic sweepOut();
        cmp_en = 1'b1;
        for (int a = 0; a < 128; a++) begin
            addrO = 7'(a);
            tick();
        end
    endtask

    task automatic applyStimulus(input string name, input bit poke);
        int bound = 4;
        int cyc = 0;
        int last = 0;
        int seq [$];
        int expq [$];
        for (int i = 0; i < n_prog; i++) begin
            bound += kk[i] + 6 + ((i > 0) ? 1 : 0) + 12;
            if (expq.size() == 0 || expq[$] != kk[i]) expq.push_back(kk[i]);
        end
        cmp_en = 1'b0;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        @(negedge clk);
        checkOutput({name, "_done_drop"}, 32'(ap_done), 32'd0);
        if (poke) begin
            addrA = 10'd0; dataA = 16'h7fff; enA = 1'b1;
            addrI = 3'd1;  dataI = 5'd0;     enI = 1'b1;
        end
        while (!ap_done && cyc < bound) begin
            if (currInstruction != 0 && int'(currInstruction) != last) begin
                last = int'(currInstruction);
                seq.push_back(last);
            end
            @(negedge clk);
            cyc++;
            enA = 1'b0; enI = 1'b0;
        end
        checkOutput({name, "_done"}, 32'(ap_done), 32'd1);
        checkOutput({name, "_ninstr"}, 32'(seq.size()), 32'(expq.size()));
        for (int j = 0; j < expq.size() && j < seq.size(); j++)
            checkOutput({name, "_curr_seq"}, 32'(seq[j]), 32'(expq[j]));
        if (ap_done) begin
            for (int i = 0; i < n_prog; i++)
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) begin
                        ref_o[16 * i + 4 * r + c] = expectedC(i, r, c);
                        ref_v[16 * i + 4 * r + c] = 1'b1;
                    end
        end
        @(posedge clk);
        #1;
        sweepOut();
    endtask

    task automatic checkAt(input string name, input int a, input logic [31:0] exp);
        addrO = 7'(a);
        #1;
        checkOutput(name, dataO, exp);
    endtask

    initial begin
        rst = 1'b1; ap_start = 1'b0;
        enA = 1'b0; enB = 1'b0; enI = 1'b0;
        addrA = '0; addrB = '0; dataA = '0; dataB = '0;
        addrI = '0; dataI = '0; addrO = '0;
        for (int a = 0; a < 128; a++) begin ref_o[a] = '0; ref_v[a] = 1'b0; end
        repeat (3) tick();
        rst = 1'b0;
        mon_on = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checkOutput("reset_done", 32'(ap_done), 32'd0);
        checkOutput("reset_curr", 32'(currInstruction), 32'd0);
        tick();

        // Diagonal K=1: out[4r+c] = (r+1)(c+1).
        n_prog = 1; kk[0] = 1;
        for (int r = 0; r < 4; r++) begin
            am[0][r][0] = 16'(r + 1);
            bm[0][0][r] = 16'(r + 1);
        end
        loadProgram();
        applyStimulus("diag", 1'b0);
        checkAt("diag_out15", 15, 32'd16);
        checkAt("diag_out6", 6, 32'd6);
        checkAt("diag_out0", 0, 32'd1);

        // Constant K=2: every entry -3*7*2.
        n_prog = 1; kk[0] = 2;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 2; k++) begin
                am[0][r][k] = -16'sd3;
                bm[0][k][r] = 16'sd7;
            end
        loadProgram();
        applyStimulus("const", 1'b0);
        checkAt("const_out5", 5, 32'hFFFFFFD6);
        repeat (3) tick();
        @(negedge clk);
        checkOutput("done_hold", 32'(ap_done), 32'd1);
        tick();

        // K=2 then K=1, with host writes attempted while busy.
        n_prog = 2; kk[0] = 2; kk[1] = 1;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 2; k++) begin
                am[0][r][k] = 16'($urandom);
                bm[0][k][r] = 16'($urandom);
            end
        am[0][0][0] = 16'sd1;
        for (int r = 0; r < 4; r++) begin
            am[1][r][0] = 16'sd2;
            bm[1][0][r] = 16'sd5;
        end
        loadProgram();
        applyStimulus("two_seg", 1'b1);
        checkAt("two_seg_out31", 31, 32'd10);

        // Reset in the middle of a run: back to idle, no results written.
        n_prog = 1; kk[0] = 5;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 5; k++) begin
                am[0][r][k] = 16'($urandom);
                bm[0][k][r] = 16'($urandom);
            end
        loadProgram();
        cmp_en = 1'b0;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checkOutput("midrun_curr", 32'(currInstruction), 32'd5);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrun_rst_done", 32'(ap_done), 32'd0);
        checkOutput("midrun_rst_curr", 32'(currInstruction), 32'd0);
        tick();
        sweepOut();

        // Empty program: done almost immediately, results untouched.
        n_prog = 0;
        loadProgram();
        applyStimulus("empty", 1'b0);

        // K=3 at full scale: wraps by default, clamps with saturation.
        n_prog = 1; kk[0] = 3;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 3; k++) begin
                am[0][r][k] = 16'sd32767;
                bm[0][k][r] = 16'sd32767;
            end
        loadProgram();
        applyStimulus("big", 1'b0);
`ifdef SYSTOLIC_SAT_EN
        checkAt("big_out9", 9, 32'h7FFFFFFF);
`else
        checkAt("big_out9", 9, -32'sd1073938429);
`endif

        // Randomized programs, the first one filling all eight instruction slots.
        for (int t = 0; t < 3; t++) begin
            n_prog = (t == 0) ? 8 : int'($urandom_range(1, 7));
            for (int i = 0; i < n_prog; i++) begin
                kk[i] = int'($urandom_range(1, 12));
                for (int r = 0; r < 4; r++)
                    for (int k = 0; k < kk[i]; k++) begin
                        am[i][r][k] = 16'($urandom);
                        bm[i][k][r] = 16'($urandom);
                    end
            end
            loadProgram();
            applyStimulus("random", 1'b0);
        end

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/systolic_top.md
# systolic_top

4×4 output-stationary systolic-array matrix-multiply accelerator with host-loaded operand, instruction and result memories. The host writes pre-skewed A/B streams and a list of inner dimensions, pulses `ap_start`, waits for `ap_done`, then reads 16 signed 32-bit results per instruction. It sits as the top-level compute block behind a simple memory-mapped host port.

## Interface

- No parameters; sizes are fixed constants (see Structure).
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `addrA`  in  10  A write address = 256·row + col
- `dataA`  in  16  A write data (signed)
- `enA`  in  1  A write enable
- `addrB`, `dataB`, `enB`: same widths and meaning, for memory B
- `addrI`  in  3  instruction write address
- `dataI`  in  5  instruction (inner dimension K; 0 = end of program)
- `enI`  in  1  instruction write enable
- `addrO`  in  7  result read address
- `dataO`  out  32  result word, combinational read of `out_mem[addrO]`
- `ap_start`  in  1  start pulse
- `ap_done`  out  1  program complete (level)
- `currInstruction`  out  5  K of the instruction executing; 0 when not busy

## Operation

- Memories:
  - A and B: 4 rows × 256 columns × 16 bit each.
  - Instruction memory: 8 × 5 bit.
  - Output memory: 128 × 32 bit.
  - Memory contents are not reset.
- Host writes take effect at the clock edge when the enable is high. Writes while busy are ignored.
- Segment layout: instruction i streams L_i = K_i + 6 columns, plus 1 more if i > 0. Segment i starts where segment i−1 ended (base_0 = 0). Data is pre-skewed in memory, so the DUT does no skewing.
- Column address wraps modulo 256.
- Each stream cycle, for each r in 0..3:
  - A[r][col] enters the left edge of PE row r.
  - B[r][col] enters the top edge of PE column r.
- Each PE, per cycle:
  - acc += a·b (signed 16×16 product, 32-bit accumulate, wraps).
  - Forwards a to the right and b downward through registers.
- FSM states:
  - IDLE: on `ap_start`, go to FETCH with i = 0 and col = 0.
  - FETCH: read instr[i]. If it is 0, or i = 8, go to DONE. Otherwise go to CLEAR.
  - CLEAR: zero all accumulators and pipeline registers.
  - STREAM: issue L_i column reads, one per cycle.
  - DRAIN: 8 cycles, until the last product reaches PE(3,3).
  - STORE: write out_mem[16i + 4r + c] = acc(r,c) for all 16 entries in one cycle. Increment i and return to FETCH.
  - DONE: `ap_done` = 1. Go to FETCH (restart at i = 0, col = 0) on `ap_start`.
- `ap_start` in any other state is ignored.
- Result entries beyond the executed instructions keep their prior value.

## Timing

- Reset values: `ap_done` = 0, `currInstruction` = 0, state = IDLE, i = 0, col = 0.
- Reset takes effect mid-operation: return to IDLE. Partial results already written stay in memory.
- Operand memories use a synchronous read with 1-cycle latency; the FSM accounts for it.
- `ap_done` asserts no later than Σ(L_i + 12) + 4 cycles after the `ap_start` edge.
- `ap_done` stays high until reset or the next accepted `ap_start`. It deasserts the cycle after acceptance.
- `dataO` follows `addrO` in the same cycle.
- Host write and FSM read of the same address in the same cycle: the FSM reads the old value (writes are gated while busy anyway).

## Configuration

- `SYSTOLIC_SAT_EN`:
  - Defined: accumulators saturate at +2147483647 and −2147483648.
  - Undefined (default): two's-complement wrap.

## Structure

- Package `systolic_pkg` holds:
  - Constants: N = 4, DATA_W = 16, ACC_W = 32, MEM_COLS = 256, INST_DEPTH = 8, OUT_DEPTH = 128, DRAIN_CYC = 8.
  - The FSM state enum.
- One sub-module, `systolic_pe`: multiply-accumulate, forward registers, clear input.
- The top level instantiates the 4×4 PE grid, the memories and the FSM.

## Test plan

- Reset, then hold idle → `ap_done` = 0, `currInstruction` = 0.
- Program K = 1, end. Set A[r][r] = r+1 and B[c][c] = c+1 (all else 0); start → `ap_done`; out[4r+c] = (r+1)(c+1), e.g. out[15] = 16.
- Program K = 2. Skewed A all −3, B all 7 → all 16 outputs = −42 (0xFFFFFFD6).
- Program K = 2, K = 1, end. Second segment base = 8, with one leading zero column → outputs 16..31 correct, and `currInstruction` shows 2 then 1.
- instr[0] = 0, start → `ap_done` within 4 cycles; out_mem unchanged.
- Program K = 3, all operands 32767 → outputs −1073938429. With `SYSTOLIC_SAT_EN` → 2147483647.
